// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared FSM state types and bank-credit limits for the segment scheduler
package sa_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } top_state_e;

  typedef enum logic {
    F_IDLE = 1'b0,
    F_WAIT = 1'b1
  } fill_state_e;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_RUN  = 2'd1,
    C_WAIT = 2'd2
  } cons_state_e;

  // Two banks in the ping-pong buffer, so at most two filled-but-unconsumed segments.
  localparam int unsigned FULL_MAX = 2;
  localparam int unsigned CREDIT_W = 2;

endpackage

// File: rtl/pp_credit_cnt.sv
// rtl/pp_credit_cnt.sv - saturating 0..FULL_MAX bank credit counter with sticky over/underflow flag
module pp_credit_cnt
  import sa_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CREDIT_W-1:0] cnt_o,
  output logic                err_o
);

  localparam logic [CREDIT_W-1:0] MaxCnt = CREDIT_W'(FULL_MAX);

  logic [CREDIT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Simultaneous inc and dec cancel; a lone inc at max or dec at zero saturates and flags.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_i) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == MaxCnt) err_d = 1'b1;
      else                 cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/pp_seg_scheduler.sv
// rtl/pp_seg_scheduler.sv - schedules producer fills and consumer reads of segments through a ping-pong buffer
module pp_seg_scheduler
  import sa_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int WORDS_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [CNT_W-1:0]   num_segs,
  input  logic [WORDS_W-1:0] seg_words,
  output logic               busy,
  output logic               done,
  output logic [WORDS_W-1:0] pp_seg_words,
  output logic               pp_fill_req,
  input  logic               pp_fill_done,
  output logic               pp_consume_req,
  output logic               pp_cons_commit,
  input  logic               pp_consume_done,
  output logic               src_start,
  output logic [CNT_W-1:0]   src_seg_idx,
  output logic               cons_start,
  output logic [CNT_W-1:0]   cons_seg_idx,
  input  logic               cons_done,
  output logic               err
);

  top_state_e          state_q, state_d;
  fill_state_e         fstate_q, fstate_d;
  cons_state_e         cstate_q, cstate_d;
  logic [CNT_W-1:0]    num_segs_q, num_segs_d;
  logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [CNT_W-1:0]    cons_cnt_q, cons_cnt_d;
  logic [CNT_W-1:0]    src_idx_q, src_idx_d;
  logic [CNT_W-1:0]    cons_idx_q, cons_idx_d;
  logic [WORDS_W-1:0]  words_q, words_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fill_req_q, fill_req_d;
  logic                src_start_q, src_start_d;
  logic                cons_req_q, cons_req_d;
  logic                cons_start_q, cons_start_d;
  logic                commit_q, commit_d;
  logic                err_q, err_d;
  logic                credit_clr, credit_inc, credit_dec, credit_err;
  logic [CREDIT_W-1:0] full_cnt;
  logic                spurious;

  pp_credit_cnt u_credit (
    .clk   (clk),
    .rst   (rst),
    .clr_i (credit_clr),
    .inc_i (credit_inc),
    .dec_i (credit_dec),
    .cnt_o (full_cnt),
    .err_o (credit_err)
  );

  // Buffer handshakes arriving when the matching FSM is not waiting for them.
  assign spurious = (pp_fill_done    && (fstate_q != F_WAIT)) ||
                    (pp_consume_done && (cstate_q != C_WAIT)) ||
                    (cons_done       && (cstate_q != C_RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fstate_q     <= F_IDLE;
      cstate_q     <= C_IDLE;
      num_segs_q   <= '0;
      fill_cnt_q   <= '0;
      cons_cnt_q   <= '0;
      src_idx_q    <= '0;
      cons_idx_q   <= '0;
      words_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fill_req_q   <= 1'b0;
      src_start_q  <= 1'b0;
      cons_req_q   <= 1'b0;
      cons_start_q <= 1'b0;
      commit_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fstate_q     <= fstate_d;
      cstate_q     <= cstate_d;
      num_segs_q   <= num_segs_d;
      fill_cnt_q   <= fill_cnt_d;
      cons_cnt_q   <= cons_cnt_d;
      src_idx_q    <= src_idx_d;
      cons_idx_q   <= cons_idx_d;
      words_q      <= words_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fill_req_q   <= fill_req_d;
      src_start_q  <= src_start_d;
      cons_req_q   <= cons_req_d;
      cons_start_q <= cons_start_d;
      commit_q     <= commit_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fstate_d     = fstate_q;
    cstate_d     = cstate_q;
    num_segs_d   = num_segs_q;
    fill_cnt_d   = fill_cnt_q;
    cons_cnt_d   = cons_cnt_q;
    src_idx_d    = src_idx_q;
    cons_idx_d   = cons_idx_q;
    words_d      = words_q;
    err_d        = err_q;
    done_d       = 1'b0;
    fill_req_d   = 1'b0;
    src_start_d  = 1'b0;
    cons_req_d   = 1'b0;
    cons_start_d = 1'b0;
    commit_d     = 1'b0;
    credit_clr   = 1'b0;
    credit_inc   = 1'b0;
    credit_dec   = 1'b0;

    if (abort) begin
      // Abort outranks everything, including error capture and job completion.
      state_d    = ST_IDLE;
      fstate_d   = F_IDLE;
      cstate_d   = C_IDLE;
      fill_cnt_d = '0;
      cons_cnt_d = '0;
      src_idx_d  = '0;
      cons_idx_d = '0;
      credit_clr = 1'b1;
    end else begin
      err_d = err_q || spurious || credit_err;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            err_d = 1'b0;
            if (num_segs != '0) begin
              state_d    = ST_RUN;
              num_segs_d = num_segs;
              words_d    = seg_words;
              fill_cnt_d = '0;
              cons_cnt_d = '0;
              src_idx_d  = '0;
              cons_idx_d = '0;
              credit_clr = 1'b1;
            end else begin
              done_d = 1'b1;
            end
          end
        end

        ST_RUN: begin
          case (fstate_q)
            F_IDLE: begin
              if ((fill_cnt_q < num_segs_q) && (full_cnt < CREDIT_W'(FULL_MAX))) begin
                fstate_d    = F_WAIT;
                fill_req_d  = 1'b1;
                src_start_d = 1'b1;
                src_idx_d   = fill_cnt_q;
              end
            end
            F_WAIT: begin
              if (pp_fill_done) begin
                fstate_d   = F_IDLE;
                fill_cnt_d = fill_cnt_q + 1'b1;
                credit_inc = 1'b1;
              end
            end
            default: fstate_d = F_IDLE;
          endcase

          case (cstate_q)
            C_IDLE: begin
              if (full_cnt != '0) begin
                cstate_d     = C_RUN;
                cons_req_d   = 1'b1;
                cons_start_d = 1'b1;
                cons_idx_d   = cons_cnt_q;
              end
            end
            C_RUN: begin
              if (cons_done) begin
                cstate_d = C_WAIT;
                commit_d = 1'b1;
              end
            end
            C_WAIT: begin
              if (pp_consume_done) begin
                cstate_d   = C_IDLE;
                cons_cnt_d = cons_cnt_q + 1'b1;
                credit_dec = 1'b1;
                if ((cons_cnt_q + 1'b1) == num_segs_q) begin
                  state_d  = ST_IDLE;
                  fstate_d = F_IDLE;
                  done_d   = 1'b1;
                end
              end
            end
            default: cstate_d = C_IDLE;
          endcase
        end

        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN);
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pp_seg_words   = words_q;
  assign pp_fill_req    = fill_req_q;
  assign src_start      = src_start_q;
  assign src_seg_idx    = src_idx_q;
  assign pp_consume_req = cons_req_q;
  assign cons_start     = cons_start_q;
  assign cons_seg_idx   = cons_idx_q;
  assign pp_cons_commit = commit_q;
  assign err            = err_q;

endmodule

// File: tb/tb_pp_seg_scheduler.sv
// tb/tb_pp_seg_scheduler.sv - scoreboard bench for the ping-pong segment scheduler
module tb_pp_seg_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] num_segs;
  logic [31:0] seg_words;
  logic        busy, done, pp_fill_req, pp_consume_req, pp_cons_commit;
  logic        src_start, cons_start, err;
  logic [31:0] pp_seg_words;
  logic [15:0] src_seg_idx, cons_seg_idx;
  logic        pp_fill_done, cons_done, cdone_r, cdone_man, pp_consume_done;

  assign pp_consume_done = cdone_r | cdone_man;

  int total = 0;
  int bad   = 0;
  int n_fill = 0, n_creq = 0, n_done = 0;
  int epoch = 0;
  int cons_delay = 0;
  int src_q[$];
  int cons_q[$];
  int base_fill, base_creq, base_done;

  always #5 clk = ~clk;

  pp_seg_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_segs(num_segs), .seg_words(seg_words),
    .busy(busy), .done(done), .pp_seg_words(pp_seg_words),
    .pp_fill_req(pp_fill_req), .pp_fill_done(pp_fill_done),
    .pp_consume_req(pp_consume_req), .pp_cons_commit(pp_cons_commit),
    .pp_consume_done(pp_consume_done),
    .src_start(src_start), .src_seg_idx(src_seg_idx),
    .cons_start(cons_start), .cons_seg_idx(cons_seg_idx),
    .cons_done(cons_done), .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic push_job(input int n);
    for (int i = 0; i < n; i++) begin
      src_q.push_back(i);
      cons_q.push_back(i);
    end
  endtask

  task automatic do_start(input int n, input int w);
    num_segs  = 16'(n);
    seg_words = 32'(w);
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (n_done != d0) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  // Buffer responders: fill completes immediately, consumer after cons_delay, release immediately.
  initial begin : fill_resp
    pp_fill_done = 1'b0;
    forever begin
      @(negedge clk);
      pp_fill_done = 1'b0;
      if (!rst && pp_fill_req) pp_fill_done = 1'b1;
    end
  end

  initial begin : cons_resp
    int ep;
    cons_done = 1'b0;
    forever begin
      @(negedge clk);
      cons_done = 1'b0;
      if (!rst && cons_start) begin
        ep = epoch;
        repeat (cons_delay) @(negedge clk);
        if (ep == epoch && !rst) cons_done = 1'b1;
      end
    end
  end

  initial begin : release_resp
    cdone_r = 1'b0;
    forever begin
      @(negedge clk);
      cdone_r = 1'b0;
      if (!rst && pp_cons_commit) cdone_r = 1'b1;
    end
  end

  // Scoreboard side: every issued index is popped from the expected queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (pp_fill_req || src_start) begin
        n_fill++;
        chk("fill_src_pair", pp_fill_req, src_start);
        chk("src_q_avail", src_q.size() > 0, 1);
        if (src_q.size() > 0) chk("src_seg_idx", src_seg_idx, src_q.pop_front());
      end
      if (pp_consume_req || cons_start) begin
        n_creq++;
        chk("cons_pair", pp_consume_req, cons_start);
        chk("cons_q_avail", cons_q.size() > 0, 1);
        if (cons_q.size() > 0) chk("cons_seg_idx", cons_seg_idx, cons_q.pop_front());
      end
      if (done) n_done++;
    end
  end

  initial begin : main
    rst = 1'b1; start = 1'b0; abort = 1'b0; cdone_man = 1'b0;
    num_segs = '0; seg_words = '0;
    repeat (3) cyc();
    chk("rst_pulses", {busy, done, pp_fill_req, pp_consume_req, pp_cons_commit, src_start, cons_start, err}, 0);
    chk("rst_idx", {src_seg_idx, cons_seg_idx}, 0);
    chk("rst_words", pp_seg_words, 0);
    rst = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // Three segments, immediate responses, with first-request latency.
    base_fill = n_fill; base_done = n_done;
    cons_delay = 0;
    push_job(3);
    do_start(3, 16);
    chk("t1_busy", busy, 1);
    chk("t1_req_early", pp_fill_req, 0);
    cyc();
    chk("t1_req_lat2", pp_fill_req, 1);
    chk("t1_first_idx", src_seg_idx, 0);
    chk("t1_words", pp_seg_words, 16);
    wait_done(base_done, 200, "t1");
    chk("t1_busy_at_done", busy, 0);
    repeat (5) cyc();
    chk("t1_done_cnt", n_done - base_done, 1);
    chk("t1_fills", n_fill - base_fill, 3);
    chk("t1_err", err, 0);
    chk("t1_q_empty", src_q.size() + cons_q.size(), 0);

    // Stalled consumer: fills stop at two banks until the first release.
    base_fill = n_fill; base_done = n_done;
    cons_delay = 50;
    push_job(4);
    do_start(4, 64);
    repeat (40) cyc();
    chk("t2_fills_stalled", n_fill - base_fill, 2);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        cyc();
        if (pp_consume_done) seen = 1'b1;
      end
      chk("t2_release_seen", seen, 1);
      chk("t2_fills_at_release", n_fill - base_fill, 2);
    end
    wait_done(base_done, 400, "t2");
    repeat (3) cyc();
    chk("t2_done_cnt", n_done - base_done, 1);
    chk("t2_fills", n_fill - base_fill, 4);
    chk("t2_q_empty", src_q.size() + cons_q.size(), 0);

    // Empty job.
    base_fill = n_fill; base_creq = n_creq; base_done = n_done;
    cons_delay = 0;
    do_start(0, 8);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    cyc();
    chk("t3_done_pulse", done, 0);
    repeat (5) cyc();
    chk("t3_no_fill", n_fill - base_fill, 0);
    chk("t3_no_cons", n_creq - base_creq, 0);
    chk("t3_done_cnt", n_done - base_done, 1);

    // Abort after the second fill, then a clean restart from index 0.
    base_fill = n_fill; base_done = n_done;
    cons_delay = 20;
    push_job(5);
    do_start(5, 32);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        cyc();
        if (n_fill - base_fill == 2) seen = 1'b1;
      end
      chk("t4_two_fills", seen, 1);
    end
    cyc(); cyc();
    abort = 1'b1;
    epoch++;
    cyc();
    abort = 1'b0;
    src_q.delete();
    cons_q.delete();
    chk("t4_busy_after_abort", busy, 0);
    repeat (25) cyc();
    chk("t4_no_done", n_done - base_done, 0);
    chk("t4_no_more_fills", n_fill - base_fill, 2);
    base_done = n_done;
    cons_delay = 0;
    push_job(2);
    do_start(2, 4);
    wait_done(base_done, 200, "t4_restart");
    cyc();
    chk("t4_restart_err", err, 0);
    chk("t4_q_empty", src_q.size() + cons_q.size(), 0);

    // Spurious release while idle is sticky until the next start.
    cdone_man = 1'b1;
    cyc();
    cdone_man = 1'b0;
    chk("t5_err_set", err, 1);
    repeat (5) cyc();
    chk("t5_err_held", err, 1);
    base_done = n_done;
    push_job(1);
    do_start(1, 2);
    chk("t5_err_clr", err, 0);
    wait_done(base_done, 100, "t5");
    chk("t5_err_after", err, 0);

    // Reset mid-job: outputs drop immediately and nothing fires after release.
    cons_delay = 10;
    push_job(4);
    do_start(4, 99);
    repeat (6) cyc();
    rst = 1'b1;
    epoch++;
    #1;
    chk("t6_rst_pulses", {busy, done, pp_fill_req, pp_consume_req, pp_cons_commit, src_start, cons_start, err}, 0);
    chk("t6_rst_idx", {src_seg_idx, cons_seg_idx}, 0);
    chk("t6_rst_words", pp_seg_words, 0);
    repeat (3) cyc();
    rst = 1'b0;
    src_q.delete();
    cons_q.delete();
    base_fill = n_fill; base_creq = n_creq; base_done = n_done;
    repeat (20) cyc();
    chk("t6_quiet", (n_fill - base_fill) + (n_creq - base_creq) + (n_done - base_done), 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pp_seg_scheduler.md
PP_SEG_SCHEDULER -- requirements
Module: pp_seg_scheduler

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the segment count and segment index.
REQ-002 Parameter WORDS_W, default 32, sets the width of the segment word count.
REQ-003 Ports, clock and reset first; the block SHALL use one clock; reset is asynchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  job start pulse.
- abort  in  1  synchronous job cancel.
- num_segs  in  CNT_W  segments in the job; sampled on accepted start.
- seg_words  in  WORDS_W  words per segment; sampled on accepted start.
- busy  out  1  job active.
- done  out  1  1-cycle job-complete pulse.
- pp_seg_words  out  WORDS_W  registered copy of seg_words, driven to the ping-pong buffer.
- pp_fill_req  out  1  1-cycle fill-arm pulse to the ping-pong buffer.
- pp_fill_done  in  1  ping-pong buffer: fill bank complete.
- pp_consume_req  out  1  1-cycle consume-arm pulse.
- pp_cons_commit  out  1  1-cycle consumer-commit pulse.
- pp_consume_done  in  1  ping-pong buffer: bank released.
- src_start  out  1  producer (DMA) start pulse.
- src_seg_idx  out  CNT_W  segment index for the producer.
- cons_start  out  1  consumer (array) start pulse.
- cons_seg_idx  out  CNT_W  segment index for the consumer.
- cons_done  in  1  consumer finished reading the bank.
- err  out  1  sticky protocol error.

Function
REQ-004 Top FSM SHALL have states IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-005 start in IDLE with num_segs≠0 SHALL latch num_segs and seg_words, clear fill_cnt, cons_cnt and full_cnt, and enter RUN on the next edge.
REQ-006 start in IDLE with num_segs=0 SHALL stay in IDLE, pulse done on the next cycle, and issue no requests.
REQ-007 start while in RUN SHALL be ignored.
REQ-008 full_cnt (0..2) SHALL count filled, unconsumed banks.
REQ-009 Fill FSM F_IDLE→F_WAIT: in RUN, when fill_cnt<num_segs and full_cnt<2, it SHALL pulse pp_fill_req and src_start together with src_seg_idx=fill_cnt.
REQ-010 In F_WAIT, pp_fill_done SHALL increment fill_cnt and full_cnt and return the fill FSM to F_IDLE; the next fill request is issued no earlier than the following cycle.
REQ-011 Consume FSM C_IDLE→C_RUN: when full_cnt>0, it SHALL pulse pp_consume_req and cons_start together with cons_seg_idx=cons_cnt.
REQ-012 In C_RUN, cons_done SHALL cause a pp_cons_commit pulse on the next cycle, with transition to C_WAIT.
REQ-013 In C_WAIT, pp_consume_done SHALL decrement full_cnt, increment cons_cnt, and return the consume FSM to C_IDLE.
REQ-014 Simultaneous full_cnt increment and decrement SHALL leave full_cnt unchanged.
REQ-015 When cons_cnt reaches num_segs, the block SHALL pulse done for one cycle, deassert busy, and return to IDLE in the same edge.
REQ-016 At most one pp_fill_req and one pp_consume_req SHALL be outstanding at any time; fill and consume SHALL overlap freely.
REQ-017 abort SHALL return all FSMs to idle and clear all counters on the next edge, with no done pulse; abort has priority over every other event.
REQ-018 err SHALL set on pp_fill_done outside F_WAIT, on pp_consume_done outside C_WAIT, or on cons_done outside C_RUN.
REQ-019 err SHALL be cleared only by rst or by an accepted start.
REQ-020 All outputs SHALL be registered; start-to-first-pp_fill_req latency SHALL be 2 cycles.

Reset
REQ-021 While rst=1: all FSMs SHALL be idle, all counters 0, all pulse outputs 0, busy=0, err=0, and all idx outputs and pp_seg_words 0.
REQ-022 rst asserted mid-job SHALL abandon the job silently; no pulse SHALL be emitted on deassertion.

Structure
REQ-023 The FSM state enums and the full_cnt maximum (2 banks) SHALL reside in shared package sa_pkg.
REQ-024 One sub-module SHALL exist: pp_credit_cnt, the saturating 0..2 up/down counter with an error flag.

Verification
REQ-025 num_segs=3, seg_words=16, immediate pp_fill_done and cons_done -> src_seg_idx 0,1,2 and cons_seg_idx 0,1,2 in order, exactly one done, err=0.
REQ-026 Consumer stalled (cons_done held off 50 cycles), num_segs=4 -> exactly 2 fills issued, then no pp_fill_req until the first pp_consume_done.
REQ-027 num_segs=0 -> done one cycle after start, with no pp_fill_req or pp_consume_req.
REQ-028 abort asserted after the second fill, num_segs=5 -> busy=0 next cycle, no done, and a subsequent start runs cleanly from index 0.
REQ-029 Spurious pp_consume_done while in C_IDLE -> err=1 and held until the next start.
REQ-030 rst pulsed mid-job -> all outputs 0 in the same cycle, and no pulses after release.
